wash_phase_timer: RTL
=====================

Name: wash_phase_timer

Overview:
- Phase timekeeper for the washing-machine controller; it is the other end of the controller's `Tempo` input.
- Watches the controller's phase outputs (`molho`, `lavar`, `enxague`, `centrifugar`, `pausar`) and loads a per-phase duration on every phase entry.
- Counts prescaled ticks and returns a one-cycle `Tempo` pulse when the phase time has elapsed.
- Freezes the spin countdown while paused (lid open) and resumes it afterwards.

Parameters:
- PRESCALE, 1000: clk cycles per time tick; legal range 1..2^PRE_W-1.
- PRE_W, 16: prescaler counter width.
- CNT_W, 8: remaining-tick counter width.
- T_MOLHO, 20: soak duration in ticks.
- T_LAVAR, 30: wash duration in ticks (LAVAR and LAVAR2).
- T_ENXAGUE, 20: rinse duration in ticks (ENXAGUE and ENXAGUE2).
- T_CENTRIFUGAR, 15: spin duration in ticks, excluding paused time.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- molho  in  1  controller soak output.
- lavar  in  1  controller wash output.
- enxague  in  1  controller rinse output.
- centrifugar  in  1  controller spin output.
- pausar  in  1  controller pause output.
- Tempo  out  1  registered one-cycle pulse: phase time elapsed; drives the controller's Tempo.
- restante  out  CNT_W  registered remaining ticks of the current phase.
- fase  out  3  registered phase code: 0 idle, 1 molho, 2 lavar, 3 enxague, 4 centrifugar; pause keeps 4.
- fase_err  out  1  sticky, registered: more than one phase input was high in the same cycle.

Behaviour:
- Reset (reset=0, async): Tempo=0, restante=0, fase=0, fase_err=0, prescaler=0, done flag=0. Reset mid-phase aborts the countdown with no pulse.
- Phase decode (combinational):
  - pausar → "hold".
  - Otherwise priority centrifugar>enxague>lavar>molho gives codes 4/3/2/1; no input high → 0.
  - Any clock edge with more than one input high sets fase_err; it clears only on reset. Decode still uses the priority result.
- Entry: an edge where the decoded code is non-zero, not hold, and differs from fase:
  - fase←code, restante←duration (0 is treated as 1), prescaler←0, done←0, Tempo←0.
  - Sequences enxague→lavar and spin→wait are ordinary changes.
  - The controller's Mealy outputs switch in the same cycle Tempo is high, so the next phase is detected on the edge right after the pulse.
- Hold (pausar=1): fase, restante, prescaler and done are frozen; Tempo←0. A hold arriving when fase≠4 is still frozen; fase_err is not set for this case.
- Resume: pausar falls with centrifugar=1 while fase=4. This is not an entry; counting continues from the frozen values.
- Counting (fase≠0, not hold, no entry, done=0):
  - Prescaler increments each edge.
  - When prescaler==PRESCALE-1 (a tick): prescaler←0, restante←restante-1.
  - If restante was 1: restante←0, Tempo←1 for exactly one cycle, done←1.
- After done: Tempo stays 0 and the counter is idle until the next entry; a second pulse within one phase is forbidden.
- Latency: Tempo rises exactly D×PRESCALE clock edges after the entry edge, plus any cycles spent in hold.
- Idle (decoded 0, not hold): fase←0, restante←0, prescaler←0, done←0, Tempo←0. No pulse is ever issued in idle.
- Simultaneous events:
  - Hold and tick on the same edge: hold wins, no decrement.
  - Entry and tick on the same edge: entry wins.
- Arithmetic: unsigned, no wrap. restante never decrements below 0.

Test Plan:
1. PRESCALE=4, T_MOLHO=3, molho rises at edge E → Tempo=1 exactly on edge E+12 for one cycle; restante steps 3,2,1,0 at E+4, E+8, E+12.
2. Pulse ends molho, lavar=1 on the next edge → fase=2, restante=T_LAVAR; Tempo low; next pulse after T_LAVAR×PRESCALE edges.
3. PRESCALE=4, T_CENTRIFUGAR=5:
   - Enter spin, assert pausar for 10 cycles after 6 cycles of spin, then centrifugar again → no reload; Tempo fires 30 edges after entry.
   - restante stays at 4 throughout the pause.
4. molho held high for 3×T_MOLHO×PRESCALE cycles with no phase change → exactly one Tempo pulse; restante stays 0.
5. reset low mid-lavar (restante=7) → all outputs 0 immediately (async). After release with inputs idle → no Tempo; fase=0.
6. molho=1 and lavar=1 together for one cycle → fase_err=1 and stays 1; fase=2 (priority); reset clears fase_err.

Source files
------------

// File: rtl/wash_phase_timer.sv
// wash_phase_timer: timekeeper for the wash controller phases; returns a one-cycle Tempo pulse when a phase's time elapses.
// Ports: clk, reset (async active-low), molho/lavar/enxague/centrifugar/pausar (controller phase outputs),
//        Tempo (elapsed pulse), restante (ticks left), fase (0 idle,1 molho,2 lavar,3 enxague,4 centrifugar), fase_err (sticky multi-phase flag).
module wash_phase_timer #(
  parameter int PRESCALE      = 1000,
  parameter int PRE_W         = 16,
  parameter int CNT_W         = 8,
  parameter int T_MOLHO       = 20,
  parameter int T_LAVAR       = 30,
  parameter int T_ENXAGUE     = 20,
  parameter int T_CENTRIFUGAR = 15
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             molho,
  input  logic             lavar,
  input  logic             enxague,
  input  logic             centrifugar,
  input  logic             pausar,
  output logic             Tempo,
  output logic [CNT_W-1:0] restante,
  output logic [2:0]       fase,
  output logic             fase_err
);
  // a zero duration still needs one tick so every phase produces its pulse
  localparam logic [CNT_W-1:0] L_M = CNT_W'(T_MOLHO == 0 ? 1 : T_MOLHO);
  localparam logic [CNT_W-1:0] L_L = CNT_W'(T_LAVAR == 0 ? 1 : T_LAVAR);
  localparam logic [CNT_W-1:0] L_E = CNT_W'(T_ENXAGUE == 0 ? 1 : T_ENXAGUE);
  localparam logic [CNT_W-1:0] L_C = CNT_W'(T_CENTRIFUGAR == 0 ? 1 : T_CENTRIFUGAR);
  logic [PRE_W-1:0] r_pre;
  logic             r_done;
  logic [2:0]       w_code;
  logic [2:0]       w_sum;
  logic [CNT_W-1:0] w_dur;
  logic             w_tick;
  // pausar is not a phase, so it never contributes to the overlap check
  assign w_sum  = 3'(molho) + 3'(lavar) + 3'(enxague) + 3'(centrifugar);
  assign w_code = centrifugar ? 3'd4 : enxague ? 3'd3 : lavar ? 3'd2 : molho ? 3'd1 : 3'd0;
  assign w_dur  = w_code == 3'd4 ? L_C : w_code == 3'd3 ? L_E : w_code == 3'd2 ? L_L : L_M;
  assign w_tick = r_pre == PRE_W'(PRESCALE - 1);
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      Tempo    <= 1'b0;
      restante <= '0;
      fase     <= 3'd0;
      fase_err <= 1'b0;
      r_pre    <= '0;
      r_done   <= 1'b0;
    end else begin
      Tempo <= 1'b0;
      if (w_sum > 3'd1) fase_err <= 1'b1;
      // hold freezes everything; resuming spin is not an entry because fase is still 4
      if (!pausar) begin
        if (w_code == 3'd0) begin
          fase     <= 3'd0;
          restante <= '0;
          r_pre    <= '0;
          r_done   <= 1'b0;
        end else if (w_code != fase) begin
          fase     <= w_code;
          restante <= w_dur;
          r_pre    <= '0;
          r_done   <= 1'b0;
        end else if (!r_done) begin
          r_pre <= w_tick ? '0 : r_pre + 1'b1;
          if (w_tick) begin
            restante <= restante > CNT_W'(1) ? restante - 1'b1 : '0;
            if (restante <= CNT_W'(1)) begin
              Tempo  <= 1'b1;
              r_done <= 1'b1;
            end
          end
        end
      end
    end
  end
endmodule
